addsub_seq: RTL

Multi-precision add/subtract sequencer. It accepts a WORDS×W-bit operand pair plus a mode bit over a valid/ready handshake. It runs the operation one W-bit limb per cycle through a single carry-in-capable W-bit add/sub slice, chaining the carry between limbs. It returns the full-width sum/difference with C, V and Z flags over a second valid/ready handshake. It sits between the command source (register file/test harness) and result consumers, time-sharing one narrow adder across a wide operand.

---
 rtl/addsub_seq_pkg.sv | 16 +
 rtl/addsub_cin_slice.sv | 30 +++
 rtl/addsub_seq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/addsub_seq_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// sequencer state encoding and the default limb geometry.
package addsub_seq_pkg;

    // Default limb width and limb count.
    localparam int DEF_W     = 4;
    localparam int DEF_WORDS = 4;

    // Sequencer states, fixed 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : addsub_seq_pkg

// File: rtl/addsub_cin_slice.sv
// One W-bit add/subtract limb with carry-in. B is inverted when M=1 so the
// caller supplies the two's-complement +1 through Cin on the first limb only.
// Also exposes the carry into the MSB so the caller can form signed overflow.
module addsub_cin_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         m,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         cmsb_in
);

    logic [W-1:0] b_x;
    logic [W:0]   sum_full;
    logic [W-1:0] sum_low;

    // Full-width limb sum plus a (W-1)-bit sum whose top bit is the carry into the MSB.
    always_comb begin
        b_x      = b ^ {W{m}};
        sum_full = {1'b0, a} + {1'b0, b_x} + {{W{1'b0}}, cin};
        sum_low  = {1'b0, a[W-2:0]} + {1'b0, b_x[W-2:0]} + {{(W-1){1'b0}}, cin};
        s        = sum_full[W-1:0];
        cout     = sum_full[W];
        cmsb_in  = sum_low[W-1];
    end

endmodule : addsub_cin_slice

// File: rtl/addsub_seq.sv
// Multi-precision add/subtract sequencer. Accepts an N-bit operand pair,
// walks it one W-bit limb per cycle through a single carry-chained slice,
// and presents the N-bit result with C/V/Z flags until the consumer takes it.
module addsub_seq
    import addsub_seq_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int WORDS = DEF_WORDS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W*WORDS-1:0]   in_a,
    input  logic [W*WORDS-1:0]   in_b,
    input  logic                 in_m,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W*WORDS-1:0]   out_s,
    output logic                 out_c,
    output logic                 out_v,
    output logic                 out_z,
    output logic                 busy
);

    localparam int N  = W * WORDS;
    localparam int KW = $clog2(WORDS);
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic            carry_q, carry_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic            m_q, m_d;
    logic [N-1:0]    s_q, s_d;
    logic            c_q, c_d;
    logic            v_q, v_d;
    logic            z_q, z_d;

    logic [W-1:0]    a_limb;
    logic [W-1:0]    b_limb;
    logic [W-1:0]    s_limb;
    logic            limb_cout;
    logic            limb_cmsb;

    assign a_limb = a_q[int'(k_q)*W +: W];
    assign b_limb = b_q[int'(k_q)*W +: W];

    addsub_cin_slice #(.W(W)) u_slice (
        .a       (a_limb),
        .b       (b_limb),
        .m       (m_q),
        .cin     (carry_q),
        .s       (s_limb),
        .cout    (limb_cout),
        .cmsb_in (limb_cmsb)
    );

    // Next-state and datapath: capture on accept, one limb per RUN cycle, hold in DONE.
    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a
        // variable unassigned; that is what keeps this block free of latches.
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        s_d     = s_q;
        c_d     = c_q;
        v_d     = v_q;
        z_d     = z_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    m_d     = in_m;
                    carry_d = in_m;   // the +1 of A + ~B + 1 enters here only
                    k_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                s_d[int'(k_q)*W +: W] = s_limb;
                carry_d               = limb_cout;
                if (k_q == K_LAST) begin
                    c_d     = limb_cout;
                    v_d     = limb_cout ^ limb_cmsb;
                    z_d     = (s_d == '0);   // every limb has been rewritten by now
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            c_q     <= c_d;
            v_q     <= v_d;
            z_q     <= z_d;
        end
    end

    // Operand capture registers.
    always_ff @(posedge clk) begin
        // NOTE: operands carry no reset: they are always loaded at accept
        // before RUN reads them, so a reset term would only add logic.
        a_q <= a_d;
        b_q <= b_d;
        m_q <= m_d;
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_s     = s_q;
    assign out_c     = c_q;
    assign out_v     = v_q;
    assign out_z     = z_q;

endmodule : addsub_seq
